// File: rtl/fp_result_queue_pkg.sv
// Shared FP32 field constants and the result classification type used by the
// result queue and its classifier.
package float_type;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_DENORM  = 3'd1,
    CLS_NORMAL  = 3'd2,
    CLS_POS_INF = 3'd3,
    CLS_NEG_INF = 3'd4,
    CLS_NAN     = 3'd5
  } fp_class_t;

endpackage

// File: rtl/fp_result_queue_classify.sv
// Combinational FP32 bit-pattern classifier; flags are not considered.
module fp_classify
  import float_type::*;
(
  input  logic [31:0] value_i,
  output fp_class_t   cls_o
);

  logic [FP_EXP_W-1:0] exp_w;
  logic [FP_MAN_W-1:0] man_w;

  assign exp_w = value_i[30:23];
  assign man_w = value_i[22:0];

  always_comb begin
    cls_o = CLS_NORMAL;
    if (exp_w == '0) begin
      cls_o = (man_w == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (exp_w == FP_EXP_MAX) begin
      if (man_w != '0) begin
        cls_o = CLS_NAN;
      end else begin
        cls_o = value_i[31] ? CLS_NEG_INF : CLS_POS_INF;
      end
    end
  end

endmodule

// File: rtl/fp_result_queue.sv
// Elastic FIFO behind the FP32 multiplier: stores result, flags and class per
// entry, and keeps sticky exception flags plus a saturating exception counter.
module fp_result_queue
  import float_type::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_u,
  input  logic                       in_o,
  input  logic                       in_n,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_flags,
  output fp_class_t                  out_class,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       status_clear,
  output logic                       sticky_u,
  output logic                       sticky_o,
  output logic                       sticky_n,
  output logic [CNT_W-1:0]           exc_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
    fp_class_t   cls;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            wr_entry_w;
  entry_t            head_w;
  fp_class_t         in_cls_w;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [2:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              full_w, empty_w;
  logic              accept_w, pop_w, flagged_w;
  logic [2:0]        in_flags_w;

  fp_classify u_classify (
    .value_i (in_result),
    .cls_o   (in_cls_w)
  );

  // Handshake depends only on registered occupancy (and reset), never on out_ready.
  assign full_w    = (level_q == LVL_W'(DEPTH));
  assign empty_w   = (level_q == '0);
  assign in_ready  = !full_w && !rst;
  assign out_valid = !empty_w && !rst;

  assign accept_w   = in_valid && in_ready;
  assign pop_w      = out_valid && out_ready;
  assign in_flags_w = {in_n, in_o, in_u};
  assign flagged_w  = accept_w && (in_flags_w != 3'b000);

  assign wr_entry_w = '{result: in_result, flags: in_flags_w, cls: in_cls_w};
  assign head_w     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (accept_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_w)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({accept_w, pop_w})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A flagged accept in the same cycle as a clear still registers.
    if (status_clear) begin
      sticky_d = 3'b000;
      cnt_d    = '0;
    end
    if (accept_w) sticky_d = sticky_d | in_flags_w;
    if (flagged_w && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= 3'b000;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) mem_q[wr_ptr_q] <= wr_entry_w;
  end

  assign out_result = out_valid ? head_w.result : 32'h0;
  assign out_flags  = out_valid ? head_w.flags  : 3'b000;
  assign out_class  = out_valid ? head_w.cls    : CLS_ZERO;
  assign level      = level_q;
  assign sticky_u   = sticky_q[0];
  assign sticky_o   = sticky_q[1];
  assign sticky_n   = sticky_q[2];
  assign exc_count  = cnt_q;

endmodule

// File: tb/tb_fp_result_queue.sv
// Randomized scoreboard bench for fp_result_queue; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_fp_result_queue;
  import float_type::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = 32'h0;
  logic        in_u = 1'b0, in_o = 1'b0, in_n = 1'b0;
  logic        out_ready = 1'b0;
  logic        status_clear = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  fp_class_t   out_class;
  logic [2:0]  level;
  logic        sticky_u, sticky_o, sticky_n;
  logic [7:0]  exc_count;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_out_result;
  logic [2:0]  d2_out_flags;
  fp_class_t   d2_out_class;
  logic [2:0]  d2_level;
  logic        d2_sticky_u, d2_sticky_o, d2_sticky_n;
  logic [1:0]  d2_exc_count;

  always #5 clk = ~clk;

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_u(in_u), .in_o(in_o), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_class(out_class), .level(level),
    .status_clear(status_clear), .sticky_u(sticky_u), .sticky_o(sticky_o),
    .sticky_n(sticky_n), .exc_count(exc_count)
  );

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_result(in_result), .in_u(in_u), .in_o(in_o), .in_n(in_n),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_result(d2_out_result),
    .out_flags(d2_out_flags), .out_class(d2_out_class), .level(d2_level),
    .status_clear(status_clear), .sticky_u(d2_sticky_u), .sticky_o(d2_sticky_o),
    .sticky_n(d2_sticky_n), .exc_count(d2_exc_count)
  );

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    int          c;
  } exp_t;

  exp_t       exp_q[$];
  int         pre_size = 0;
  logic [2:0] m_sticky = 3'b000;
  int         m_cnt = 0;
  int         m_cnt2 = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference classification: 0 zero, 1 denorm, 2 normal, 3 +inf, 4 -inf, 5 nan.
  function automatic int ref_class(input logic [31:0] w);
    int e;
    int m;
    e = int'(w[30:23]);
    m = int'(w[22:0]);
    if (e == 255) return (m != 0) ? 5 : (w[31] ? 4 : 3);
    if (e == 0)   return (m != 0) ? 1 : 0;
    return 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the model state, then retire popped heads.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      pre_size = exp_q.size();
      if (rst) begin
        check("in_ready_rst", in_ready, 1'b0);
        check("out_valid_rst", out_valid, 1'b0);
      end else begin
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        check("out_valid", out_valid, exp_q.size() > 0);
        check("level", level, exp_q.size());
        check("sticky_u", sticky_u, m_sticky[0]);
        check("sticky_o", sticky_o, m_sticky[1]);
        check("sticky_n", sticky_n, m_sticky[2]);
        check("exc_count", exc_count, m_cnt);
        check("exc_count_w2", d2_exc_count, m_cnt2);
        if (exp_q.size() > 0) begin
          check("out_result", out_result, exp_q[0].r);
          check("out_flags", out_flags, exp_q[0].f);
          check("out_class", out_class, exp_q[0].c);
          if (out_ready) begin
            $display("pop  %08h flags %03b class %0d", out_result, out_flags, out_class);
            void'(exp_q.pop_front());
          end
        end else begin
          check("out_result_empty", out_result, 32'h0);
          check("out_flags_empty", out_flags, 3'b000);
          check("out_class_empty", out_class, 0);
        end
      end
    end
  end

  // Drive one cycle of stimulus, then advance the model as the next edge will.
  task automatic step(input logic v, input logic [31:0] d, input logic [2:0] fl,
                      input logic ordy, input logic clr, input logic r);
    exp_t e;
    @(negedge clk);
    in_valid     = v;
    in_result    = d;
    in_u         = fl[0];
    in_o         = fl[1];
    in_n         = fl[2];
    out_ready    = ordy;
    status_clear = clr;
    rst          = r;
    #2;
    if (r) begin
      exp_q.delete();
      m_sticky = 3'b000;
      m_cnt    = 0;
      m_cnt2   = 0;
    end else begin
      if (clr) begin
        m_sticky = 3'b000;
        m_cnt    = 0;
        m_cnt2   = 0;
      end
      if (v && pre_size < DEPTH) begin
        e.r = d;
        e.f = fl;
        e.c = ref_class(d);
        exp_q.push_back(e);
        m_sticky = m_sticky | fl;
        if (fl != 3'b000) begin
          m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
        $display("push %08h flags %03b clear %0b", d, fl, clr);
      end
    end
  endtask

  logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h00400000, 32'h7F800000,
                                32'hFF800000, 32'h7FC00000, 32'h3F800000, 32'hC0C00000};

  initial begin
    logic [31:0] w;
    logic [2:0]  f;
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    step(1'b1, 32'h40C00000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    step(1'b1, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00400000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFF800000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3F800000, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      w = (i % 2 == 0) ? specials[i % 8] : $urandom;
      step(1'b1, w, 3'b000, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    step(1'b1, 32'h7FC00000, 3'b100, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 32'h00000001, 3'b001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, specials[i + 3], 3'b010, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 800; i++) begin
      w = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      f[0] = ($urandom_range(0, 3) == 0);
      f[1] = ($urandom_range(0, 3) == 0);
      f[2] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, w, f, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
